// File: rtl/ifu_fetch.sv
// -----------------------------------------------------------------------------
// ifu_fetch
//
// Instruction fetch unit. It sits between the PC register and decode. Each
// cycle it offers the current PC as a word fetch on the instruction bus
// (req/gnt/rvalid). It keeps the address of every granted fetch so that the
// data, which returns in order, can be tagged with its address. Returned
// instructions are buffered in a small FIFO that feeds decode through a
// valid/ready handshake.
//
// A jump flushes the FIFO. Fetches that are still in flight at that point are
// remembered as "discard" credits, and their responses are dropped when they
// arrive.
//
// Ports
//   clk            clock
//   rst            asynchronous, active-high reset
//   pc_i           current PC from the PC register
//   jump_flag_i    flush request; pc_i is stale in this cycle
//   fetch_stall_o  1 = PC register must hold (pc_i not accepted this cycle)
//   ibus_req_o     fetch request
//   ibus_addr_o    fetch address (always pc_i)
//   ibus_gnt_i     request accepted this cycle
//   ibus_rvalid_i  read data valid
//   ibus_rdata_i   read data
//   inst_valid_o   FIFO head valid
//   inst_o         FIFO head instruction, NOP_INST when empty
//   inst_addr_o    FIFO head address, 0 when empty
//   inst_ready_i   decode accepts the head
// -----------------------------------------------------------------------------
module ifu_fetch #(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter int                DEPTH    = 2,
  parameter logic [DATA_W-1:0] NOP_INST = 32'h00000013
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              jump_flag_i,
  output logic              fetch_stall_o,
  output logic              ibus_req_o,
  output logic [ADDR_W-1:0] ibus_addr_o,
  input  logic              ibus_gnt_i,
  input  logic              ibus_rvalid_i,
  input  logic [DATA_W-1:0] ibus_rdata_i,
  output logic              inst_valid_o,
  output logic [DATA_W-1:0] inst_o,
  output logic [ADDR_W-1:0] inst_addr_o,
  input  logic              inst_ready_i
);

  // Pointer width and counter width. Counters need one extra bit so that the
  // value DEPTH itself is representable.
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  // The credit sum adds three counters, so it gets two more bits again.
  localparam int SW = CW + 2;
  localparam logic [SW-1:0] DEPTH_S = SW'(DEPTH);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  // Instruction FIFO (address + data per entry).
  logic [ADDR_W-1:0] fifo_addr [DEPTH];
  logic [DATA_W-1:0] fifo_data [DEPTH];
  logic [PW-1:0]     fifo_wptr_reg;
  logic [PW-1:0]     fifo_rptr_reg;
  logic [CW-1:0]     fifo_count_reg;

  // Address queue: one entry per request on the bus whose response has not
  // come back yet, including requests that will be discarded. Its head is
  // always the address belonging to the next rvalid.
  logic [ADDR_W-1:0] aq_mem [DEPTH];
  logic [PW-1:0]     aq_wptr_reg;
  logic [PW-1:0]     aq_rptr_reg;

  // Live in-flight fetches and in-flight fetches orphaned by a jump.
  logic [CW-1:0]     outstanding_reg;
  logic [CW-1:0]     discard_reg;

  // ---------------------------------------------------------------------------
  // Combinational control
  // ---------------------------------------------------------------------------
  logic [SW-1:0] credit_sum;
  logic          accept;
  logic          resp_any;
  logic          resp_disc;
  logic          resp_data;
  logic          fifo_pop;
  logic          fifo_push;
  logic [CW-1:0] fifo_count_next;
  logic [CW-1:0] outstanding_next;
  logic [CW-1:0] discard_next;

  // Credit is computed from registered counts only. Every entry that might
  // still land in the FIFO holds one credit, so the FIFO cannot overflow.
  assign credit_sum = SW'(fifo_count_reg) + SW'(outstanding_reg) + SW'(discard_reg);

  // Request is gated by rst so that nothing is issued while in reset.
  assign ibus_req_o    = !rst && !jump_flag_i && (credit_sum < DEPTH_S);
  assign ibus_addr_o   = pc_i;
  assign accept        = ibus_req_o && ibus_gnt_i;
  assign fetch_stall_o = !accept;

  // A response is meaningful only if something is in flight. Discarded
  // responses are always older than live ones, so they are consumed first.
  assign resp_any  = ibus_rvalid_i && ((discard_reg != '0) || (outstanding_reg != '0));
  assign resp_disc = ibus_rvalid_i && (discard_reg != '0);
  // Live data is written unless a jump flushes it in the same cycle.
  assign resp_data = ibus_rvalid_i && (discard_reg == '0) && (outstanding_reg != '0)
                     && !jump_flag_i;

  assign fifo_push = resp_data;
  assign fifo_pop  = inst_valid_o && inst_ready_i && !jump_flag_i;

  always_comb begin
    fifo_count_next  = fifo_count_reg;
    outstanding_next = outstanding_reg;
    discard_next     = discard_reg;
    if (jump_flag_i) begin
      // All live fetches become orphans. A response arriving in this very
      // cycle retires one of them (whether it was live or already orphaned).
      fifo_count_next  = '0;
      outstanding_next = '0;
      discard_next     = discard_reg + outstanding_reg - CW'(resp_any);
    end else begin
      fifo_count_next  = fifo_count_reg + CW'(fifo_push) - CW'(fifo_pop);
      outstanding_next = outstanding_reg + CW'(accept) - CW'(resp_data);
      discard_next     = discard_reg - CW'(resp_disc);
    end
  end

  // ---------------------------------------------------------------------------
  // Registered control state
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fifo_wptr_reg   <= '0;
      fifo_rptr_reg   <= '0;
      fifo_count_reg  <= '0;
      aq_wptr_reg     <= '0;
      aq_rptr_reg     <= '0;
      outstanding_reg <= '0;
      discard_reg     <= '0;
    end else begin
      fifo_count_reg  <= fifo_count_next;
      outstanding_reg <= outstanding_next;
      discard_reg     <= discard_next;

      if (jump_flag_i) begin
        // Flushing the FIFO: realign both pointers.
        fifo_wptr_reg <= '0;
        fifo_rptr_reg <= '0;
      end else begin
        if (fifo_push) fifo_wptr_reg <= fifo_wptr_reg + 1'b1;
        if (fifo_pop)  fifo_rptr_reg <= fifo_rptr_reg + 1'b1;
      end

      // The address queue is never flushed: orphaned fetches still return
      // data and must pop their own entry.
      if (accept)   aq_wptr_reg <= aq_wptr_reg + 1'b1;
      if (resp_any) aq_rptr_reg <= aq_rptr_reg + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Storage arrays (no reset; contents are qualified by the counters)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (fifo_push) begin
      fifo_addr[fifo_wptr_reg] <= aq_mem[aq_rptr_reg];
      fifo_data[fifo_wptr_reg] <= ibus_rdata_i;
    end
    if (accept) begin
      aq_mem[aq_wptr_reg] <= pc_i;
    end
  end

  // ---------------------------------------------------------------------------
  // Decode-side outputs
  // ---------------------------------------------------------------------------
  assign inst_valid_o = (fifo_count_reg != '0);
  assign inst_o       = inst_valid_o ? fifo_data[fifo_rptr_reg] : NOP_INST;
  assign inst_addr_o  = inst_valid_o ? fifo_addr[fifo_rptr_reg] : '0;

endmodule

// File: tb/tb_ifu_fetch.sv
module tb_ifu_fetch;
  localparam int DEPTH = 2;
  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk;
  logic        rst;
  logic [31:0] pc_i;
  logic        jump_flag_i;
  logic        fetch_stall_o;
  logic        ibus_req_o;
  logic [31:0] ibus_addr_o;
  logic        ibus_gnt_i;
  logic        ibus_rvalid_i;
  logic [31:0] ibus_rdata_i;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [31:0] inst_addr_o;
  logic        inst_ready_i;

  ifu_fetch #(.ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .NOP_INST(NOP)) dut (
    .clk(clk), .rst(rst), .pc_i(pc_i), .jump_flag_i(jump_flag_i),
    .fetch_stall_o(fetch_stall_o), .ibus_req_o(ibus_req_o),
    .ibus_addr_o(ibus_addr_o), .ibus_gnt_i(ibus_gnt_i),
    .ibus_rvalid_i(ibus_rvalid_i), .ibus_rdata_i(ibus_rdata_i),
    .inst_valid_o(inst_valid_o), .inst_o(inst_o), .inst_addr_o(inst_addr_o),
    .inst_ready_i(inst_ready_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // ---------------- reference model ----------------
  // Every fetch on the bus is a pending record; a jump marks all of them dead.
  typedef struct { logic [31:0] addr; bit dead; int gcyc; } pend_t;
  typedef struct { logic [31:0] addr; logic [31:0] data; } ent_t;
  pend_t pend[$];
  ent_t  fq[$];
  bit    m_acc;

  int          rv_mode = 0;   // 0 none, 1 asap, 2 random, 3 manual
  logic [31:0] jump_target = 32'h0;

  // samples taken at the falling edge of the last cycle
  logic s_req, s_stall, s_valid;
  logic [31:0] s_addr, s_inst, s_iaddr;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit m_req();
    return !rst && !jump_flag_i && ((fq.size() + pend.size()) < DEPTH);
  endfunction

  task automatic model_step();
    pend_t p;
    bit    resp;
    m_acc = m_req() && ibus_gnt_i;
    resp  = ibus_rvalid_i && (pend.size() > 0);
    if (resp) p = pend.pop_front();
    if (jump_flag_i) begin
      fq.delete();
      foreach (pend[i]) pend[i].dead = 1'b1;
    end else begin
      if (fq.size() > 0 && inst_ready_i) void'(fq.pop_front());
      if (resp && !p.dead) fq.push_back('{p.addr, ibus_rdata_i});
      if (m_acc) pend.push_back('{pc_i, 1'b0, cyc});
    end
  endtask

  task automatic cycle();
    bit due;
    due = (pend.size() > 0) && (pend[0].gcyc < cyc);
    case (rv_mode)
      0: ibus_rvalid_i = 1'b0;
      1: ibus_rvalid_i = due;
      2: ibus_rvalid_i = due ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 15) == 0);
      default: ;
    endcase
    if (rv_mode != 3) ibus_rdata_i = $urandom;
    @(negedge clk);
    s_req = ibus_req_o; s_stall = fetch_stall_o; s_valid = inst_valid_o;
    s_addr = ibus_addr_o; s_inst = inst_o; s_iaddr = inst_addr_o;
    chk("req", s_req, m_req());
    chk("ibus_addr", s_addr, pc_i);
    chk("stall", s_stall, !(m_req() && ibus_gnt_i));
    chk("inst_valid", s_valid, fq.size() > 0);
    chk("inst", s_inst, (fq.size() > 0) ? fq[0].data : NOP);
    chk("inst_addr", s_iaddr, (fq.size() > 0) ? fq[0].addr : 32'h0);
    $display("cyc %0d pc=%h j=%b gnt=%b rv=%b rdy=%b | req=%b stall=%b v=%b inst=%h iaddr=%h",
             cyc, pc_i, jump_flag_i, ibus_gnt_i, ibus_rvalid_i, inst_ready_i,
             s_req, s_stall, s_valid, s_inst, s_iaddr);
    model_step();
    @(posedge clk);
    #1;
    cyc++;
    if (jump_flag_i) pc_i = jump_target;
    else if (m_acc)  pc_i = pc_i + 32'd4;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    jump_flag_i = 1'b0; ibus_gnt_i = 1'b0; ibus_rvalid_i = 1'b0;
    ibus_rdata_i = 32'h0; inst_ready_i = 1'b0; pc_i = 32'h0;
    #2;
    @(posedge clk);
    #1;
    chk("rst_valid", inst_valid_o, 1'b0);
    chk("rst_inst", inst_o, NOP);
    chk("rst_iaddr", inst_addr_o, 32'h0);
    chk("rst_req", ibus_req_o, 1'b0);
    chk("rst_stall", fetch_stall_o, 1'b1);
    pend.delete(); fq.delete();
    rst = 1'b0;
    cyc = 0;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [31:0] pc; logic gnt; logic rv; logic [31:0] rdata; logic rdy;
    logic req; logic stall; logic valid; logic [31:0] inst; logic [31:0] iaddr;
  } vec_t;
  vec_t vt [6];

  initial begin
    vt[0] = '{32'h0, 1, 0, 32'h0,        1, 1, 0, 0, NOP,          32'h0};
    vt[1] = '{32'h4, 1, 1, 32'h11111111, 1, 1, 0, 0, NOP,          32'h0};
    vt[2] = '{32'h8, 1, 1, 32'h22222222, 1, 0, 1, 1, 32'h11111111, 32'h0};
    vt[3] = '{32'h8, 1, 0, 32'h0,        1, 1, 0, 1, 32'h22222222, 32'h4};
    vt[4] = '{32'hC, 0, 1, 32'h33333333, 1, 1, 1, 0, NOP,          32'h0};
    vt[5] = '{32'hC, 0, 0, 32'h0,        1, 1, 1, 1, 32'h33333333, 32'h8};

    // in-order streaming, table driven
    do_reset();
    rv_mode = 3;
    for (int i = 0; i < 6; i++) begin
      pc_i = vt[i].pc; ibus_gnt_i = vt[i].gnt; ibus_rvalid_i = vt[i].rv;
      ibus_rdata_i = vt[i].rdata; inst_ready_i = vt[i].rdy;
      cycle();
      chk("tbl_req", s_req, vt[i].req);
      chk("tbl_stall", s_stall, vt[i].stall);
      chk("tbl_valid", s_valid, vt[i].valid);
      chk("tbl_inst", s_inst, vt[i].inst);
      chk("tbl_iaddr", s_iaddr, vt[i].iaddr);
    end

    // back-pressure: decode stalled, credits run out
    do_reset();
    pc_i = 32'h0; ibus_gnt_i = 1'b1; inst_ready_i = 1'b0; rv_mode = 1;
    cycle(); cycle();
    cycle();
    chk("bp_req_c2", s_req, 1'b0);
    cycle();
    chk("bp_req_c3", s_req, 1'b0);
    chk("bp_stall_c3", s_stall, 1'b1);
    chk("bp_pc_held", pc_i, 32'h8);
    inst_ready_i = 1'b1;
    cycle();
    chk("bp_req_pop_cycle", s_req, 1'b0);
    inst_ready_i = 1'b0;
    cycle();
    chk("bp_req_after_pop", s_req, 1'b1);

    // grant withheld at 0x10
    do_reset();
    pc_i = 32'h10; ibus_gnt_i = 1'b0; inst_ready_i = 1'b1; rv_mode = 1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("nognt_req", s_req, 1'b1);
      chk("nognt_addr", s_addr, 32'h10);
      chk("nognt_stall", s_stall, 1'b1);
    end
    ibus_gnt_i = 1'b1;
    cycle();
    chk("gnt_stall", s_stall, 1'b0);
    chk("gnt_pc_adv", pc_i, 32'h14);

    // jump with two fetches outstanding
    do_reset();
    pc_i = 32'h20; ibus_gnt_i = 1'b1; inst_ready_i = 1'b0; rv_mode = 0;
    cycle(); cycle();
    jump_flag_i = 1'b1; jump_target = 32'h100; ibus_gnt_i = 1'b0;
    cycle();
    chk("jmp_req", s_req, 1'b0);
    chk("jmp_stall", s_stall, 1'b1);
    jump_flag_i = 1'b0; ibus_gnt_i = 1'b1; rv_mode = 1;
    cycle();
    chk("jmp_disc_req", s_req, 1'b0);
    for (int i = 0; i < 8; i++) begin
      cycle();
      if (s_valid) break;
    end
    chk("jmp_tgt_valid", s_valid, 1'b1);
    chk("jmp_tgt_addr", s_iaddr, 32'h100);

    // jump in the same cycle as the only response
    do_reset();
    pc_i = 32'h200; ibus_gnt_i = 1'b1; inst_ready_i = 1'b1; rv_mode = 0;
    cycle();
    jump_flag_i = 1'b1; jump_target = 32'h300; ibus_gnt_i = 1'b0;
    rv_mode = 3; ibus_rvalid_i = 1'b1; ibus_rdata_i = 32'hDEADBEEF;
    cycle();
    jump_flag_i = 1'b0; rv_mode = 0; ibus_gnt_i = 1'b1;
    cycle();
    chk("jrv_req", s_req, 1'b1);
    chk("jrv_stall", s_stall, 1'b0);
    rv_mode = 1;
    cycle(); cycle();
    chk("jrv_valid", s_valid, 1'b1);
    chk("jrv_iaddr", s_iaddr, 32'h300);

    // asynchronous reset with data buffered and one fetch in flight
    do_reset();
    pc_i = 32'h40; ibus_gnt_i = 1'b1; inst_ready_i = 1'b0; rv_mode = 1;
    cycle(); cycle();
    ibus_gnt_i = 1'b0; ibus_rvalid_i = 1'b0;
    #2;
    chk("ar_pre_valid", inst_valid_o, 1'b1);
    rst = 1'b1;
    #1;
    chk("ar_valid", inst_valid_o, 1'b0);
    chk("ar_inst", inst_o, NOP);
    chk("ar_iaddr", inst_addr_o, 32'h0);
    chk("ar_req", ibus_req_o, 1'b0);
    chk("ar_stall", fetch_stall_o, 1'b1);
    pend.delete(); fq.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    rv_mode = 3; ibus_rvalid_i = 1'b1; ibus_rdata_i = 32'hBAD0BAD0;
    cycle();
    rv_mode = 0;
    cycle();
    chk("ar_stray_ignored", s_valid, 1'b0);

    // randomized traffic against the model
    do_reset();
    rv_mode = 2;
    pc_i = 32'h1000;
    for (int i = 0; i < 2000; i++) begin
      ibus_gnt_i   = ($urandom_range(0, 3) != 0);
      inst_ready_i = ($urandom_range(0, 2) != 0);
      jump_flag_i  = ($urandom_range(0, 11) == 0);
      jump_target  = {$urandom_range(0, 32'h3FFF), 2'b00};
      cycle();
    end
    jump_flag_i = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
